irq_timer: RTL and testbench

IRQ_TIMER -- requirements
Module: irq_timer

---
 rtl/irq_timer.sv | 89 ++++++++
 tb/tb_irq_timer.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/irq_timer.sv
// Memory-mapped interval timer: TH reload, TL up-counter, TCON control/status.
// Raises a level interrupt on TL overflow, masked while the CPU is in kernel mode.
module irq_timer (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] Address,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic        PC31,
  output logic [31:0] ReadData,
  output logic        IRQ
);

  localparam int unsigned DataW = 32;
  localparam int unsigned TconW = 3;

  localparam logic [DataW-1:0] AddrTh   = 32'h4000_0000;
  localparam logic [DataW-1:0] AddrTl   = 32'h4000_0004;
  localparam logic [DataW-1:0] AddrTcon = 32'h4000_0008;

  logic [DataW-1:0] th;
  logic [DataW-1:0] tl;
  logic [TconW-1:0] tcon;

  logic selTh, selTl, selTcon;
  logic wrTh, wrTl, wrTcon;
  logic countEn, tlAtMax, overflow, statusSet;

  assign selTh   = (Address == AddrTh);
  assign selTl   = (Address == AddrTl);
  assign selTcon = (Address == AddrTcon);

  assign wrTh   = MemWrite && selTh;
  assign wrTl   = MemWrite && selTl;
  assign wrTcon = MemWrite && selTcon;

  // Counting uses the registered enable, so a TCON write affects the next cycle.
  assign countEn   = tcon[0];
  assign tlAtMax   = (tl == {DataW{1'b1}});
  assign overflow  = countEn && tlAtMax && !wrTl;
  assign statusSet = overflow && tcon[1];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      th <= '0;
    end else if (wrTh) begin
      th <= WriteData;
    end
  end

  // A software TL write preempts both increment and reload; reload takes the old TH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tl <= '0;
    end else if (wrTl) begin
      tl <= WriteData;
    end else if (countEn) begin
      tl <= tlAtMax ? th : tl + DataW'(1);
    end
  end

  // Hardware status set wins over a coincident software clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tcon <= '0;
    end else if (wrTcon) begin
      tcon <= {WriteData[2] | statusSet, WriteData[1:0]};
    end else if (statusSet) begin
      tcon[2] <= 1'b1;
    end
  end

  always_comb begin
    ReadData = '0;
    if (MemRead) begin
      if (selTh) begin
        ReadData = th;
      end else if (selTl) begin
        ReadData = tl;
      end else if (selTcon) begin
        ReadData = {(DataW - TconW)'(0), tcon};
      end
    end
  end

  assign IRQ = tcon[1] && tcon[2] && !PC31;

endmodule

// File: tb/tb_irq_timer.sv
// Directed bench for irq_timer: reload/interrupt, kernel masking, write
// priorities, decode and asynchronous reset, with hand-computed expectations.
module tb_irq_timer;

  localparam logic [31:0] AddrTh   = 32'h4000_0000;
  localparam logic [31:0] AddrTl   = 32'h4000_0004;
  localparam logic [31:0] AddrTcon = 32'h4000_0008;
  localparam logic [31:0] AddrBad  = 32'h4000_000C;

  logic        clk;
  logic        reset;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic        MemRead;
  logic        MemWrite;
  logic        PC31;
  logic [31:0] ReadData;
  logic        IRQ;

  int vectors;
  int miscompares;

  irq_timer dut (
    .clk      (clk),
    .reset    (reset),
    .Address  (Address),
    .WriteData(WriteData),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .PC31     (PC31),
    .ReadData (ReadData),
    .IRQ      (IRQ)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Bus write presented across one rising edge, launched from the preceding falling edge.
  task automatic wrReg(input logic [31:0] addr, input logic [31:0] data);
    @(negedge clk);
    Address   = addr;
    WriteData = data;
    MemWrite  = 1'b1;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    Address   = '0;
    WriteData = '0;
  endtask

  task automatic rdReg(input logic [31:0] addr, output logic [31:0] data);
    Address = addr;
    MemRead = 1'b1;
    #1;
    data    = ReadData;
    MemRead = 1'b0;
    Address = '0;
  endtask

  task automatic nextEdge();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b0;
    Address     = '0;
    WriteData   = '0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    PC31        = 1'b0;

    // Reset state
    #12;
    rdReg(AddrTh, rd);   chk("rst_th", rd, 32'h0);
    rdReg(AddrTl, rd);   chk("rst_tl", rd, 32'h0);
    rdReg(AddrTcon, rd); chk("rst_tcon", rd, 32'h0);
    chk("rst_irq", {31'h0, IRQ}, 32'h0);
    @(negedge clk);
    reset = 1'b1;

    // Reload with interrupt
    wrReg(AddrTh, 32'hFFFF_FFFD);
    wrReg(AddrTl, 32'hFFFF_FFFD);
    wrReg(AddrTcon, 32'h3);
    rdReg(AddrTl, rd);   chk("rl_tl0", rd, 32'hFFFF_FFFD);
    nextEdge();
    rdReg(AddrTl, rd);   chk("rl_tl1", rd, 32'hFFFF_FFFE);
    nextEdge();
    rdReg(AddrTl, rd);   chk("rl_tl2", rd, 32'hFFFF_FFFF);
    rdReg(AddrTcon, rd); chk("rl_tcon2", rd, 32'h3);
    nextEdge();
    rdReg(AddrTl, rd);   chk("rl_tl3", rd, 32'hFFFF_FFFD);
    rdReg(AddrTcon, rd); chk("rl_tcon3", rd, 32'h7);
    chk("rl_irq", {31'h0, IRQ}, 32'h1);
    rdReg(AddrTh, rd);   chk("rl_th", rd, 32'hFFFF_FFFD);

    // Stop counting, keep status pending; TL counts once more on this edge
    wrReg(AddrTcon, 32'h6);
    rdReg(AddrTl, rd);   chk("hold_tl", rd, 32'hFFFF_FFFE);
    chk("hold_irq", {31'h0, IRQ}, 32'h1);

    // Kernel masking
    PC31 = 1'b1; #1;
    chk("kmask_irq", {31'h0, IRQ}, 32'h0);
    PC31 = 1'b0; #1;
    chk("kunmask_irq", {31'h0, IRQ}, 32'h1);
    wrReg(AddrTcon, 32'h3);
    chk("clr_irq", {31'h0, IRQ}, 32'h0);
    rdReg(AddrTl, rd);   chk("clr_tl", rd, 32'hFFFF_FFFE);

    // Simultaneous clear and overflow
    nextEdge();
    rdReg(AddrTl, rd);   chk("sim_tl_pre", rd, 32'hFFFF_FFFF);
    wrReg(AddrTcon, 32'h3);
    rdReg(AddrTcon, rd); chk("sim_tcon", rd, 32'h7);
    rdReg(AddrTl, rd);   chk("sim_tl", rd, 32'hFFFF_FFFD);

    // TL write priority over reload
    wrReg(AddrTcon, 32'h0);
    wrReg(AddrTl, 32'hFFFF_FFFF);
    wrReg(AddrTcon, 32'h3);
    wrReg(AddrTl, 32'h10);
    rdReg(AddrTl, rd);   chk("pri_tl", rd, 32'h10);
    rdReg(AddrTcon, rd); chk("pri_tcon", rd, 32'h3);
    nextEdge();
    rdReg(AddrTl, rd);   chk("pri_tl_next", rd, 32'h11);

    // Interrupt-disabled overflow and decode
    wrReg(AddrTcon, 32'h0);
    wrReg(AddrTh, 32'h100);
    wrReg(AddrTl, 32'hFFFF_FFFF);
    wrReg(AddrTcon, 32'h1);
    nextEdge();
    rdReg(AddrTl, rd);   chk("noie_tl", rd, 32'h100);
    rdReg(AddrTcon, rd); chk("noie_tcon", rd, 32'h1);
    wrReg(AddrBad, 32'hDEAD_BEEF);
    rdReg(AddrBad, rd);  chk("bad_rd", rd, 32'h0);
    rdReg(AddrTh, rd);   chk("bad_th", rd, 32'h100);
    Address = AddrTh; #1;
    chk("noread", ReadData, 32'h0);
    Address = '0;

    // TH write coinciding with overflow reloads the old TH
    wrReg(AddrTcon, 32'h0);
    wrReg(AddrTh, 32'h50);
    wrReg(AddrTl, 32'hFFFF_FFFF);
    wrReg(AddrTcon, 32'h1);
    wrReg(AddrTh, 32'h99);
    rdReg(AddrTl, rd);   chk("thov_tl", rd, 32'h50);
    rdReg(AddrTh, rd);   chk("thov_th", rd, 32'h99);

    // Asynchronous reset mid-cycle with IRQ high
    wrReg(AddrTcon, 32'h0);
    wrReg(AddrTl, 32'h1234);
    wrReg(AddrTcon, 32'h6);
    rdReg(AddrTl, rd);   chk("pre_rst_tl", rd, 32'h1234);
    chk("pre_rst_irq", {31'h0, IRQ}, 32'h1);
    @(negedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("arst_irq", {31'h0, IRQ}, 32'h0);
    rdReg(AddrTl, rd);   chk("arst_tl", rd, 32'h0);
    rdReg(AddrTcon, rd); chk("arst_tcon", rd, 32'h0);
    rdReg(AddrTh, rd);   chk("arst_th", rd, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    nextEdge();
    nextEdge();
    rdReg(AddrTl, rd);   chk("post_rst_tl", rd, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
